// File: rtl/compression_pkg.sv
// Shared constants for the text compressor, the symbol packer and the
// receive-side expander. Symbol width is fixed by the compressor alphabet.
package compression_pkg;

   localparam int SYM_W  = 7;   // compressed symbol width
   localparam int BYTE_W = 8;   // serial link byte width
   localparam int ACC_W  = 14;  // holds one partial byte plus one full symbol
   localparam int FILL_W = 4;   // fill count 0..14

endpackage : compression_pkg

// File: rtl/symbol_accumulator.sv
// Bit accumulator for the symbol packer. Valid bits sit MSB-aligned in
// r_acc with the oldest bit at r_acc[ACC_W-1]; every bit below the fill
// point is kept at zero, so the top byte is already zero-padded whenever
// fewer than 8 bits remain.
module symbol_accumulator
   import compression_pkg::*;
(
   input  logic              clk,
   input  logic              reset,       // asynchronous, active-low
   input  logic              i_append,    // append i_sym below the current fill
   input  logic [SYM_W-1:0]  i_sym,
   input  logic              i_drain,     // remove the oldest 8 bits
   input  logic              i_pad,       // discard everything after a padded extract
   output logic [FILL_W-1:0] o_fill,
   output logic [BYTE_W-1:0] o_top_byte
);

   logic [ACC_W-1:0]  r_acc;
   logic [FILL_W-1:0] r_fill;
   logic [ACC_W-1:0]  w_sym_placed;
   logic [FILL_W-1:0] w_shift;

   // Appends only happen with fewer than 8 bits held, so the shift
   // (7 - fill) never underflows when it matters.
   assign w_shift      = FILL_W'(SYM_W) - r_fill;
   assign w_sym_placed = {{(ACC_W-SYM_W){1'b0}}, i_sym} << w_shift;

   assign o_fill     = r_fill;
   assign o_top_byte = r_acc[ACC_W-1 -: BYTE_W];

   // Accumulator and fill count: append, drain a byte, or clear after padding.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc  <= '0;
         r_fill <= '0;
      end else if (i_append) begin
         r_acc  <= r_acc | w_sym_placed;
         r_fill <= r_fill + FILL_W'(SYM_W);
      end else if (i_drain) begin
         r_acc  <= r_acc << BYTE_W;
         r_fill <= r_fill - FILL_W'(BYTE_W);
      end else if (i_pad) begin
         r_acc  <= '0;
         r_fill <= '0;
      end
   end

endmodule : symbol_accumulator

// File: rtl/symbol_packer.sv
// Packs 7-bit compressed symbols MSB-first into 8-bit bytes (8 symbols ->
// 7 bytes). A flush closes the message: any partial byte is zero-padded
// and emitted with out_last set.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and in_ready depends on registers
// only (never on out_ready).
// Optional build macro PACK_STATS_EN adds the sym_count port (accepted
// symbols since reset, wrapping at 16 bits).
module symbol_packer
   import compression_pkg::*;
(
   input  logic              clk,
   input  logic              reset,       // asynchronous, active-low
   input  logic [SYM_W-1:0]  in_sym,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   output logic [BYTE_W-1:0] out_byte,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
`ifdef PACK_STATS_EN
   ,
   output logic [15:0]       sym_count
`endif
);

   logic [BYTE_W-1:0] r_out_byte;
   logic              r_out_valid;
   logic              r_out_last;
   logic              r_flush_pending;

   logic [FILL_W-1:0] w_fill;
   logic [BYTE_W-1:0] w_top_byte;
   logic              w_slot_free;
   logic              w_accept;
   logic              w_drain;
   logic              w_pad;
   logic              w_flush_empty;
   logic              w_load;

   assign in_ready      = (w_fill < FILL_W'(BYTE_W)) && !r_flush_pending;
   assign w_accept      = in_valid && in_ready;
   assign w_slot_free   = !r_out_valid || out_ready;
   // Full bytes always leave before a flush pads the remainder.
   assign w_drain       = w_slot_free && (w_fill >= FILL_W'(BYTE_W));
   assign w_pad         = r_flush_pending && (w_fill != '0) &&
                          (w_fill < FILL_W'(BYTE_W)) && w_slot_free;
   assign w_flush_empty = r_flush_pending && (w_fill == '0);
   assign w_load        = w_drain || w_pad;

   symbol_accumulator u_acc (
      .clk        (clk),
      .reset      (reset),
      .i_append   (w_accept),
      .i_sym      (in_sym),
      .i_drain    (w_drain),
      .i_pad      (w_pad),
      .o_fill     (w_fill),
      .o_top_byte (w_top_byte)
   );

   // Output register: load a full or padded byte, otherwise hold until taken.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_byte  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else if (w_load) begin
         r_out_byte  <= w_top_byte;
         r_out_valid <= 1'b1;
         r_out_last  <= w_pad;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Flush control: a request is latched until the remainder is padded out
   // or found empty; requests while one is pending are ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_flush_pending <= 1'b0;
      end else if (r_flush_pending) begin
         if (w_pad || w_flush_empty) r_flush_pending <= 1'b0;
      end else if (flush) begin
         r_flush_pending <= 1'b1;
      end
   end

   assign out_byte  = r_out_byte;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;

`ifdef PACK_STATS_EN
   logic [15:0] r_sym_count;

   // Accepted-symbol counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        r_sym_count <= '0;
      else if (w_accept) r_sym_count <= r_sym_count + 16'd1;
   end

   assign sym_count = r_sym_count;
`endif

endmodule : symbol_packer
